ebr_dp_model: RTL and testbench

- Parametrised, single-clock, true dual-port block-RAM behavioural model.
- Generalises the fixed 9-bit, three-write-mode EBR test arrangement into one block with:
  - configurable data width and depth;
  - per-port write mode, chip-select decode and output register mode.
- Used as the golden model in EBR timing/bitstream fuzz benches and as a soft RAM in simulation-only designs.

---
 rtl/ebr_pkg.sv | 18 +
 rtl/ebr_port_out.sv | 78 +++++++
 rtl/ebr_dp_model.sv | 138 +++++++++++++
 tb/tb_ebr_dp_model.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebr_pkg.sv
// ebr_pkg: shared constants and helpers for the EBR dual-port RAM model.
//   WM_*  : per-port write-mode encodings (what a port's read latch does on a write)
//   REG_* : per-port output register mode (NOREG latency 1, OUTREG latency 2)
//   ebr_addr_width(): address width for a given depth (minimum 1 bit)
package ebr_pkg;

    localparam int unsigned WM_NORMAL          = 0;
    localparam int unsigned WM_READBEFOREWRITE = 1;
    localparam int unsigned WM_WRITETHROUGH    = 2;

    localparam int unsigned REG_NOREG  = 0;
    localparam int unsigned REG_OUTREG = 1;

    function automatic int unsigned ebr_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ebr_port_out.sv
// ebr_port_out: read-side datapath of one EBR port.
// Holds the read latch (Q) and, in OUTREG mode, the output register (R).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears Q and R)
//   en_i           port enable (clock enable and chip select both true)
//   we_i           write enable of this port
//   srst_i         synchronous output reset, active high, beats read updates
//   oce_i          output-register enable (OUTREG only)
//   wdata_i        this port's write data (used by WRITETHROUGH)
//   rdata_i        pre-edge memory word at this port's address (0 if out of range)
//   dout_o         port read data
module ebr_port_out
    import ebr_pkg::*;
#(
    parameter int unsigned DW        = 9,
    parameter int unsigned WRITEMODE = WM_NORMAL,
    parameter int unsigned REGMODE   = REG_NOREG
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          we_i,
    input  logic          srst_i,
    input  logic          oce_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (srst_i) begin
            q_d = '0;
        end else if (en_i) begin
            if (!we_i) begin
                q_d = rdata_i;
            end else if (WRITEMODE == WM_READBEFOREWRITE) begin
                q_d = rdata_i;
            end else if (WRITEMODE == WM_WRITETHROUGH) begin
                q_d = wdata_i;
            end
            // NORMAL write: latch holds
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    generate
        if (REGMODE == REG_OUTREG) begin : g_outreg
            logic [DW-1:0] r_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_q <= '0;
                end else if (srst_i) begin
                    r_q <= '0;
                end else if (oce_i) begin
                    r_q <= q_q;
                end
            end

            assign dout_o = r_q;
        end else begin : g_noreg
            logic unused_oce;
            assign unused_oce = oce_i;
            assign dout_o     = q_q;
        end
    endgenerate

endmodule

// File: rtl/ebr_dp_model.sv
// ebr_dp_model: parametrised single-clock true dual-port block-RAM model.
// Holds the memory array, cross-port write arbitration (port A wins on a shared
// address) and, optionally, the collision detector.
// Optional feature macro: EBR_COLLISION_FLAG_EN adds the COLLISION output, a
// registered one-cycle pulse after any same-address edge where both ports are
// enabled and at least one writes.
// Ports (x = A or B):
//   CLK   rising-edge clock for both ports
//   RSTN  asynchronous active-low reset of outputs (memory is kept)
//   DIx   write data          ADx  address          CEx  clock enable
//   OCEx  output-reg enable   WEx  write enable     CSx  3-bit chip select
//   RSTx  sync output reset   DOx  read data
//   COLLISION  collision pulse (only with EBR_COLLISION_FLAG_EN)
module ebr_dp_model
    import ebr_pkg::*;
#(
    parameter int unsigned DW          = 9,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WRITEMODE_A = WM_NORMAL,
    parameter int unsigned WRITEMODE_B = WM_NORMAL,
    parameter int unsigned REGMODE_A   = REG_NOREG,
    parameter int unsigned REGMODE_B   = REG_NOREG,
    parameter logic [2:0]  CSDECODE_A  = 3'b000,
    parameter logic [2:0]  CSDECODE_B  = 3'b000,
    localparam int unsigned AW         = ebr_addr_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [DW-1:0] DIA,
    input  logic [AW-1:0] ADA,
    input  logic          CEA,
    input  logic          OCEA,
    input  logic          WEA,
    input  logic [2:0]    CSA,
    input  logic          RSTA,
    output logic [DW-1:0] DOA,
    input  logic [DW-1:0] DIB,
    input  logic [AW-1:0] ADB,
    input  logic          CEB,
    input  logic          OCEB,
    input  logic          WEB,
    input  logic [2:0]    CSB,
    input  logic          RSTB,
    output logic [DW-1:0] DOB
`ifdef EBR_COLLISION_FLAG_EN
    ,
    output logic          COLLISION
`endif
);

    logic [DW-1:0] mem [DEPTH];

    logic          en_a, en_b;
    logic          in_range_a, in_range_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          wr_a, wr_b;

    assign en_a       = CEA && (CSA == CSDECODE_A);
    assign en_b       = CEB && (CSB == CSDECODE_B);
    assign in_range_a = 32'(ADA) < DEPTH;
    assign in_range_b = 32'(ADB) < DEPTH;

    // Pre-edge contents; both ports see old data on a same-edge write.
    assign rdata_a = in_range_a ? mem[ADA] : '0;
    assign rdata_b = in_range_b ? mem[ADB] : '0;

    assign wr_a = en_a && WEA && in_range_a;
    assign wr_b = en_b && WEB && in_range_b && !(wr_a && (ADA == ADB));

    // No reset on the array; writes are held off while RSTN is low.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            if (wr_a) begin
                mem[ADA] <= DIA;
            end
            if (wr_b) begin
                mem[ADB] <= DIB;
            end
        end
    end

    ebr_port_out #(
        .DW        (DW),
        .WRITEMODE (WRITEMODE_A),
        .REGMODE   (REGMODE_A)
    ) u_port_a (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .en_i    (en_a),
        .we_i    (WEA),
        .srst_i  (RSTA),
        .oce_i   (OCEA),
        .wdata_i (DIA),
        .rdata_i (rdata_a),
        .dout_o  (DOA)
    );

    ebr_port_out #(
        .DW        (DW),
        .WRITEMODE (WRITEMODE_B),
        .REGMODE   (REGMODE_B)
    ) u_port_b (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .en_i    (en_b),
        .we_i    (WEB),
        .srst_i  (RSTB),
        .oce_i   (OCEB),
        .wdata_i (DIB),
        .rdata_i (rdata_b),
        .dout_o  (DOB)
    );

`ifdef EBR_COLLISION_FLAG_EN
    logic coll_d, coll_q;

    assign coll_d = en_a && en_b && (ADA == ADB) && (WEA || WEB);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign COLLISION = coll_q;

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RSTN && coll_d) begin
            $warning("ebr_dp_model: address collision at 0x%0h", ADA);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_ebr_dp_model.sv
// Bench for ebr_dp_model: two instances with different port configurations share
// one stimulus stream; a behavioural model (plain arrays) predicts every output.
//   dut0: A NORMAL/NOREG cs=000, B READBEFOREWRITE/NOREG cs=000, DEPTH 1024
//   dut1: A WRITETHROUGH/OUTREG cs=000, B NORMAL/OUTREG cs=110, DEPTH 1000
module tb_ebr_dp_model;

    logic       CLK = 1'b0;
    logic       rstn;
    logic [8:0] dia, dib;
    logic [9:0] ada, adb;
    logic       cea, ceb, ocea, oceb, wea, web, rsta, rstb;
    logic [2:0] csa, csb;
    logic [8:0] doa0, dob0, doa1, dob1;
`ifdef EBR_COLLISION_FLAG_EN
    logic       col0, col1;
`endif

    always #5 CLK = ~CLK;

    ebr_dp_model #(
        .DW(9), .DEPTH(1024), .WRITEMODE_A(0), .WRITEMODE_B(1),
        .REGMODE_A(0), .REGMODE_B(0), .CSDECODE_A(3'b000), .CSDECODE_B(3'b000)
    ) dut0 (
        .CLK(CLK), .RSTN(rstn),
        .DIA(dia), .ADA(ada), .CEA(cea), .OCEA(ocea), .WEA(wea), .CSA(csa), .RSTA(rsta),
        .DOA(doa0),
        .DIB(dib), .ADB(adb), .CEB(ceb), .OCEB(oceb), .WEB(web), .CSB(csb), .RSTB(rstb),
        .DOB(dob0)
`ifdef EBR_COLLISION_FLAG_EN
        , .COLLISION(col0)
`endif
    );

    ebr_dp_model #(
        .DW(9), .DEPTH(1000), .WRITEMODE_A(2), .WRITEMODE_B(0),
        .REGMODE_A(1), .REGMODE_B(1), .CSDECODE_A(3'b000), .CSDECODE_B(3'b110)
    ) dut1 (
        .CLK(CLK), .RSTN(rstn),
        .DIA(dia), .ADA(ada), .CEA(cea), .OCEA(ocea), .WEA(wea), .CSA(csa), .RSTA(rsta),
        .DOA(doa1),
        .DIB(dib), .ADB(adb), .CEB(ceb), .OCEB(oceb), .WEB(web), .CSB(csb), .RSTB(rstb),
        .DOB(dob1)
`ifdef EBR_COLLISION_FLAG_EN
        , .COLLISION(col1)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Configuration mirror and model state, indexed [dut][port], port 0 = A.
    int         cfg_wm[2][2];
    int         cfg_rm[2][2];
    int         cfg_depth[2];
    logic [2:0] cfg_cs[2][2];
    logic [8:0] m_mem[2][1024];
    logic [8:0] m_q[2][2];
    logic [8:0] m_r[2][2];
    logic       m_col[2];

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_col[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_q[d][p] = '0;
                m_r[d][p] = '0;
            end
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [8:0] di_v[2];
        logic [8:0] old_v[2];
        logic [9:0] ad_v[2];
        logic [2:0] cs_v[2];
        logic       ce_v[2], we_v[2], rs_v[2], oe_v[2], en_v[2], ok_v[2];
        di_v[0] = dia;  di_v[1] = dib;
        ad_v[0] = ada;  ad_v[1] = adb;
        cs_v[0] = csa;  cs_v[1] = csb;
        ce_v[0] = cea;  ce_v[1] = ceb;
        we_v[0] = wea;  we_v[1] = web;
        rs_v[0] = rsta; rs_v[1] = rstb;
        oe_v[0] = ocea; oe_v[1] = oceb;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                en_v[p]  = ce_v[p] && (cs_v[p] == cfg_cs[d][p]);
                ok_v[p]  = int'(ad_v[p]) < cfg_depth[d];
                old_v[p] = ok_v[p] ? m_mem[d][ad_v[p]] : 9'h000;
            end
            m_col[d] = en_v[0] && en_v[1] && (ad_v[0] == ad_v[1]) && (we_v[0] || we_v[1]);
            for (int p = 0; p < 2; p++) begin
                if (cfg_rm[d][p] == 1) begin
                    if (rs_v[p]) m_r[d][p] = '0;
                    else if (oe_v[p]) m_r[d][p] = m_q[d][p];
                end
                if (rs_v[p]) m_q[d][p] = '0;
                else if (en_v[p]) begin
                    if (!we_v[p] || cfg_wm[d][p] == 1) m_q[d][p] = old_v[p];
                    else if (cfg_wm[d][p] == 2) m_q[d][p] = di_v[p];
                end
            end
            // B first, then A, so A's data is what remains on a shared address.
            if (en_v[1] && we_v[1] && ok_v[1]) m_mem[d][ad_v[1]] = di_v[1];
            if (en_v[0] && we_v[0] && ok_v[0]) m_mem[d][ad_v[0]] = di_v[0];
        end
    endtask

    task automatic check_all();
        logic [8:0] act[2][2];
        act[0][0] = doa0; act[0][1] = dob0; act[1][0] = doa1; act[1][1] = dob1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("dut%0d_do%s", d, (p == 0) ? "a" : "b"), act[d][p],
                      (cfg_rm[d][p] == 1) ? m_r[d][p] : m_q[d][p]);
            end
        end
`ifdef EBR_COLLISION_FLAG_EN
        check("dut0_collision", {8'h00, col0}, {8'h00, m_col[0]});
        check("dut1_collision", {8'h00, col1}, {8'h00, m_col[1]});
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle();
        cea = 0; ceb = 0; wea = 0; web = 0; rsta = 0; rstb = 0;
        ocea = 1; oceb = 1; csa = 3'b000; csb = 3'b000;
        dia = '0; dib = '0; ada = '0; adb = '0;
    endtask

    task automatic write_a(input logic [9:0] addr, input logic [8:0] data);
        idle(); cea = 1; wea = 1; ada = addr; dia = data;
        tick();
    endtask

    task automatic read_a(input logic [9:0] addr);
        idle(); cea = 1; ada = addr;
        tick();
    endtask

    initial begin
        cfg_wm[0][0] = 0; cfg_wm[0][1] = 1; cfg_wm[1][0] = 2; cfg_wm[1][1] = 0;
        cfg_rm[0][0] = 0; cfg_rm[0][1] = 0; cfg_rm[1][0] = 1; cfg_rm[1][1] = 1;
        cfg_cs[0][0] = 3'b000; cfg_cs[0][1] = 3'b000;
        cfg_cs[1][0] = 3'b000; cfg_cs[1][1] = 3'b110;
        cfg_depth[0] = 1024; cfg_depth[1] = 1000;

        // Reset state
        idle();
        rstn = 1'b0;
        model_reset();
        #3;
        check_all();
        @(negedge CLK);
        rstn = 1'b1;

        // Preload the address ranges used below (values never equal 0x1FF)
        for (int i = 0; i < 128; i++) write_a(10'(i), 9'($urandom_range(0, 510)));
        for (int i = 1000; i < 1024; i++) write_a(10'(i), 9'($urandom_range(0, 510)));

        // NORMAL/NOREG write then read
        write_a(10'h010, 9'h1A5);
        read_a(10'h010);
        check("normal_read", doa0, 9'h1A5);

        // READBEFOREWRITE on dut0 port B
        write_a(10'h020, 9'h055);
        idle(); ceb = 1; web = 1; adb = 10'h020; dib = 9'h0AA;
        tick();
        check("rbw_old", dob0, 9'h055);
        idle(); ceb = 1; adb = 10'h020;
        tick();
        check("rbw_new", dob0, 9'h0AA);

        // WRITETHROUGH + OUTREG on dut1 port A
        write_a(10'h030, 9'h123);
        idle();
        tick();
        check("wt_outreg", doa1, 9'h123);
        idle(); ocea = 0; cea = 1; wea = 1; ada = 10'h031; dia = 9'h0F0;
        tick();
        tick();
        check("outreg_hold", doa1, 9'h123);
        ocea = 1; cea = 0;
        tick();
        check("outreg_load", doa1, 9'h0F0);

        // Both ports write one address on one edge
        idle(); cea = 1; ceb = 1; wea = 1; web = 1;
        ada = 10'h040; adb = 10'h040; dia = 9'h111; dib = 9'h022;
        tick();
        read_a(10'h040);
        check("both_write_a", doa0, 9'h111);
        tick();
        check("both_write_a_outreg", doa1, 9'h111);
        idle(); ceb = 1; adb = 10'h040;
        tick();
        check("both_write_b", dob0, 9'h111);

        // Chip select mismatch blocks the write
        idle(); cea = 1; wea = 1; csa = 3'b101; ada = 10'h050; dia = 9'h1FF;
        tick();
        read_a(10'h050);
        assert (doa0 !== 9'h1FF) else begin
            failures++;
            $error("FAIL cs_blocked observed=%h expected=not 1ff", doa0);
        end
        checks++;

        // Synchronous output reset beats the read
        idle(); cea = 1; ada = 10'h010; rsta = 1;
        tick();
        check("rsta_clear", doa0, 9'h000);

        // Async reset in the middle of an OUTREG read
        read_a(10'h010);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async_rst_outreg", doa1, 9'h000);
        #1;
        rstn = 1'b1;
        tick();
        check("post_rst_noreg", doa0, 9'h1A5);
        tick();
        check("post_rst_outreg", doa1, 9'h1A5);

        // Randomised traffic, including out-of-range addresses on dut1
        for (int n = 0; n < 400; n++) begin
            cea  = ($urandom_range(0, 3) != 0);
            ceb  = ($urandom_range(0, 3) != 0);
            wea  = $urandom_range(0, 1) == 1;
            web  = $urandom_range(0, 1) == 1;
            ada  = ($urandom_range(0, 7) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                               : 10'($urandom_range(0, 7));
            adb  = ($urandom_range(0, 7) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                               : 10'($urandom_range(0, 7));
            dia  = 9'($urandom_range(0, 511));
            dib  = 9'($urandom_range(0, 511));
            csa  = ($urandom_range(0, 7) == 0) ? 3'b101 : 3'b000;
            csb  = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b000;
            rsta = ($urandom_range(0, 15) == 0);
            rstb = ($urandom_range(0, 15) == 0);
            ocea = ($urandom_range(0, 3) != 0);
            oceb = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
